// File: rtl/datapath_primitives_pkg.sv
// Shared widths and types for the datapath storage/selection primitives.
// Select encodings stay with the instantiating datapath.
package datapath_primitives_pkg;

    localparam int DP_W   = 16;
    localparam int M4_N   = 4;
    localparam int M8_N   = 8;

    typedef logic [DP_W-1:0] word_t;

endpackage

// File: rtl/datapath_primitives_if.sv
// Bundles the flop controls and mux data/select buses seen by the primitive top.
// The master drives loads and selects; the slave returns registered and selected data.
interface datapath_primitives_if;
    import datapath_primitives_pkg::*;

    logic                        en16;
    word_t                       d16;
    word_t                       q16;
    logic                        en1;
    logic                        d1;
    logic                        q1;
    logic [M4_N-1:0][DP_W-1:0]   m4_d;
    logic [1:0]                  m4_s;
    word_t                       m4_y;
    logic [M8_N-1:0][DP_W-1:0]   m8_d;
    logic [2:0]                  m8_s;
    word_t                       m8_y;

    modport master (
        output en16, d16, en1, d1, m4_d, m4_s, m8_d, m8_s,
        input  q16, q1, m4_y, m8_y
    );

    modport slave (
        input  en16, d16, en1, d1, m4_d, m4_s, m8_d, m8_s,
        output q16, q1, m4_y, m8_y
    );

endinterface

// File: rtl/datapath_primitives_cells.sv
// Leaf cells: enabled register with async clear, 4:1 and 8:1 selectors.
// Ports are positional-compatible with the datapath instantiations.
module flop_enable_reset #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (enable) q_d = d;
    end

    // Clear is asynchronous and wins over enable and the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end
endmodule

module mux8 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        case (s)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            3'd7:    y = d7;
            default: y = d0;
        endcase
    end
endmodule

// File: rtl/datapath_primitives.sv
// Wraps one 16-bit and one 1-bit enabled flop plus the 4:1 and 8:1 selectors
// at datapath width, exposed through a single interface.
module datapath_primitives
    import datapath_primitives_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    datapath_primitives_if.slave  bus
);

    flop_enable_reset #(.WIDTH(DP_W)) u_flop16 (
        .clock  (clk),
        .reset  (rst),
        .enable (bus.en16),
        .d      (bus.d16),
        .q      (bus.q16)
    );

    // Single-bit instance covers status-flag style registers.
    flop_enable_reset #(.WIDTH(1)) u_flop1 (
        .clock  (clk),
        .reset  (rst),
        .enable (bus.en1),
        .d      (bus.d1),
        .q      (bus.q1)
    );

    mux4 #(.WIDTH(DP_W)) u_mux4 (
        .d0 (bus.m4_d[0]),
        .d1 (bus.m4_d[1]),
        .d2 (bus.m4_d[2]),
        .d3 (bus.m4_d[3]),
        .s  (bus.m4_s),
        .y  (bus.m4_y)
    );

    mux8 #(.WIDTH(DP_W)) u_mux8 (
        .d0 (bus.m8_d[0]),
        .d1 (bus.m8_d[1]),
        .d2 (bus.m8_d[2]),
        .d3 (bus.m8_d[3]),
        .d4 (bus.m8_d[4]),
        .d5 (bus.m8_d[5]),
        .d6 (bus.m8_d[6]),
        .d7 (bus.m8_d[7]),
        .s  (bus.m8_s),
        .y  (bus.m8_y)
    );

endmodule

// File: tb/tb_datapath_primitives.sv
// Directed and random checks of the datapath primitives against a behavioural model.
module tb_datapath_primitives;
    import datapath_primitives_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_on = 1'b0;

    // Model: last value accepted at a clock edge while out of reset; zero once cleared.
    logic [15:0] exp16 = '0;
    logic        exp1  = 1'b0;

    datapath_primitives_if bus ();

    datapath_primitives dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.en16) exp16 = bus.d16;
            if (bus.en1)  exp1  = bus.d1;
        end
    end

    always @(posedge rst) begin
        exp16 = '0;
        exp1  = 1'b0;
    end

    // Every falling edge: registers vs model, selectors vs the indexed input.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_q16", bus.q16, rst ? 16'h0 : exp16);
            check("model_q1",  {15'b0, bus.q1}, rst ? 16'h0 : {15'b0, exp1});
            check("model_mux4", bus.m4_y, bus.m4_d[bus.m4_s]);
            check("model_mux8", bus.m8_y, bus.m8_d[bus.m8_s]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en16 = 1'b0; bus.d16 = '0; bus.en1 = 1'b0; bus.d1 = 1'b0;
        bus.m4_d = '0;   bus.m4_s = '0; bus.m8_d = '0; bus.m8_s = '0;

        // Power-up reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_q16", bus.q16, 16'h0);
        check("reset_q1",  {15'b0, bus.q1}, 16'h0);
        #2 rst = 1'b0;
        chk_on = 1'b1;

        // 1: load BEEF, then async clear between edges
        @(posedge clk); #1 bus.en16 = 1'b1; bus.d16 = 16'hBEEF;
        @(posedge clk); #1 check("load_beef", bus.q16, 16'hBEEF);
        bus.d16 = 16'h1234;
        #2 rst = 1'b1;
        #1 check("async_clear", bus.q16, 16'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_dominates_en", bus.q16, 16'h0);
        #2 rst = 1'b0;

        // 2: load then hold
        @(posedge clk); #1 bus.en16 = 1'b1; bus.d16 = 16'h00A5;
        @(posedge clk); #1 check("load_a5", bus.q16, 16'h00A5);
        bus.en16 = 1'b0; bus.d16 = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1 check("hold_a5", bus.q16, 16'h00A5);

        // 3: single-bit flop
        bus.en1 = 1'b1; bus.d1 = 1'b1;
        @(posedge clk); #1 check("w1_load", {15'b0, bus.q1}, 16'h0001);
        #2 rst = 1'b1;
        #1 check("w1_async_clear", {15'b0, bus.q1}, 16'h0);
        @(posedge clk); #3 rst = 1'b0;
        bus.en1 = 1'b0;

        // 4: mux4 one-hot-nibble sweep
        bus.m4_d[0] = 16'h0001; bus.m4_d[1] = 16'h0010;
        bus.m4_d[2] = 16'h0100; bus.m4_d[3] = 16'h1000;
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1 bus.m4_s = 2'(s);
            #1 check($sformatf("mux4_s%0d", s), bus.m4_y, 16'h0001 << (4 * s));
        end

        // 5: mux8 sweep and combinational tracking
        for (int i = 0; i < 8; i++) bus.m8_d[i] = 16'hA000 + 16'(i);
        for (int s = 0; s < 8; s++) begin
            @(posedge clk); #1 bus.m8_s = 3'(s);
            #1 check($sformatf("mux8_s%0d", s), bus.m8_y, 16'hA000 + 16'(s));
        end
        @(posedge clk); #1 bus.m8_s = 3'd5;
        #1 bus.m8_d[5] = 16'h5A5A;
        #1 check("mux8_track_d5", bus.m8_y, 16'h5A5A);

        // 6: random traffic with occasional mid-cycle reset pulses
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            bus.en16 = 1'($urandom_range(0, 1));
            bus.d16  = 16'($urandom);
            bus.en1  = 1'($urandom_range(0, 1));
            bus.d1   = 1'($urandom_range(0, 1));
            bus.m4_s = 2'($urandom_range(0, 3));
            bus.m8_s = 3'($urandom_range(0, 7));
            for (int i = 0; i < 4; i++) bus.m4_d[i] = 16'($urandom);
            for (int i = 0; i < 8; i++) bus.m8_d[i] = 16'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #3 rst = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
